fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RV32I core. Owns the program counter, drives the

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, zero-latency imem address,
// IF/ID pipeline register with stall/flush/redirect and a saturating fetch counter.
//
// state | meaning
// BOOT  | first edge after reset; IF/ID stays a bubble, PC holds
// RUN   | fetching; IF/ID captures imem_data every edge
// HOLD  | stalled; PC and IF/ID frozen until stall drops
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc4,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // RUN and HOLD share one priority chain; HOLD only differs by having been stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_pc    <= RESET_PC;
            if_id_pc4   <= RESET_PC + 32'd4;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                default: begin
                    if (redirect) begin
                        pc          <= redirect_pc & 32'hFFFF_FFFC;
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc_plus4;
                        if_id_inst  <= NOP_INST;
                        if_id_valid <= 1'b0;
                        state       <= RUN;
                    end else if (flush) begin
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc_plus4;
                        if_id_inst  <= NOP_INST;
                        if_id_valid <= 1'b0;
                        if (!stall) begin
                            pc <= pc_plus4;
                        end
                        state <= stall ? HOLD : RUN;
                    end else if (stall) begin
                        state <= HOLD;
                    end else begin
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc_plus4;
                        if_id_inst  <= imem_data;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                        if (fetch_count != {CNT_W{1'b1}}) begin
                            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        state <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction ROM.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0020_0093;
            32'h4:   rom = 32'h0030_0113;
            32'h8:   rom = 32'h0111_0193;
            default: rom = a ^ 32'h5A5A_0003;
        endcase
    endfunction

    always_comb imem_data = rom(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic valid, input logic [15:0] cnt, input logic [31:0] addr);
        check({tag, ".if_id_pc"},    if_id_pc, pc);
        check({tag, ".if_id_pc4"},   if_id_pc4, pc + 32'd4);
        check({tag, ".if_id_inst"},  if_id_inst, inst);
        check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        check({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, cnt});
        check({tag, ".imem_addr"},   imem_addr, addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #2 rst_n = 1'b0;
        #1 check_all("reset", 32'h0, 32'h13, 1'b0, 16'd0, 32'h0);
        step(); step();
        rst_n = 1'b1;

        // basic fetch from address 0
        step(); check_all("boot", 32'h0, 32'h13, 1'b0, 16'd0, 32'h0);
        step(); check_all("f0", 32'h0, 32'h0020_0093, 1'b1, 16'd1, 32'h4);
        step(); check_all("f4", 32'h4, 32'h0030_0113, 1'b1, 16'd2, 32'h8);

        // stall freezes everything
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_all("stall", 32'h4, 32'h0030_0113, 1'b1, 16'd2, 32'h8);
        end
        stall = 1'b0;
        step(); check_all("unstall", 32'h8, 32'h0111_0193, 1'b1, 16'd3, 32'hC);

        // redirect beats stall, low bits dropped
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h2E;
        step(); check_all("redir", 32'hC, 32'h13, 1'b0, 16'd3, 32'h2C);
        stall = 1'b0; redirect = 1'b0;
        step(); check_all("redir_f", 32'h2C, rom(32'h2C), 1'b1, 16'd4, 32'h30);

        // flush alone at PC=8
        redirect = 1'b1; redirect_pc = 32'h8;
        step(); check_all("redir8", 32'h30, 32'h13, 1'b0, 16'd4, 32'h8);
        redirect = 1'b0; flush = 1'b1;
        step(); check_all("flush", 32'h8, 32'h13, 1'b0, 16'd4, 32'hC);
        flush = 1'b0;
        step(); check_all("post_flush", 32'hC, rom(32'hC), 1'b1, 16'd5, 32'h10);

        // flush together with stall holds PC, then HOLD keeps the bubble
        flush = 1'b1; stall = 1'b1;
        step(); check_all("flush_stall", 32'h10, 32'h13, 1'b0, 16'd5, 32'h10);
        flush = 1'b0;
        step(); check_all("hold_bubble", 32'h10, 32'h13, 1'b0, 16'd5, 32'h10);
        stall = 1'b0;
        step(); check_all("hold_rel", 32'h10, rom(32'h10), 1'b1, 16'd6, 32'h14);

        // address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); check("wrap.imem_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step(); check_all("wrap", 32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1'b1, 16'd7, 32'h0);
        check("wrap.pc4_zero", if_id_pc4, 32'h0);

        // asynchronous reset mid-cycle; redirect/flush ignored in BOOT
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 32'h0, 32'h13, 1'b0, 16'd0, 32'h0);
        step();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h40; flush = 1'b1;
        step(); check_all("boot2", 32'h0, 32'h13, 1'b0, 16'd0, 32'h0);
        redirect = 1'b0; flush = 1'b0;
        step(); check_all("refetch", 32'h0, 32'h0020_0093, 1'b1, 16'd1, 32'h4);

        // counter saturation
        for (int i = 0; i < 65534; i++) step();
        check("sat.reach", {16'd0, fetch_count}, 32'd65535);
        step();
        check("sat.hold", {16'd0, fetch_count}, 32'd65535);
        check("sat.valid", {31'd0, if_id_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
